// File: rtl/ac_motor_pkg.sv
// Shared constants and types for the AC motor PWM carrier generator.
package ac_motor_pkg;

  localparam logic [1:0] MODE_TRI    = 2'd0;
  localparam logic [1:0] MODE_SAW_UP = 2'd1;
  localparam logic [1:0] MODE_SAW_DN = 2'd2;

  localparam int unsigned DEFAULT_LEVEL_BITS  = 13;
  localparam int unsigned DEFAULT_OUTPUT_BITS = 24;

  typedef enum logic {
    DirDown = 1'b0,
    DirUp   = 1'b1
  } dir_e;

endpackage

// File: rtl/ac_motor_prescaler.sv
// Step-rate prescaler: one tick every div_i+1 enabled clocks.
module ac_motor_prescaler #(
  parameter int unsigned PRESCALE_BITS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [PRESCALE_BITS-1:0] div_i,
  output logic                     tick_o
);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d;

  // Exact match only: a count already past div_i runs on to the wrap, never ticks early.
  always_comb begin
    tick_o  = en_i && (presc_q == div_i);
    presc_d = presc_q + PRESCALE_BITS'(1);
    if (!en_i || tick_o) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/ac_motor_carrier.sv
// Signed PWM carrier (triangle / saw up / saw down) with peak/valley strobes and lock flag.
module ac_motor_carrier
  import ac_motor_pkg::*;
#(
  parameter int unsigned OUTPUT_BITS   = DEFAULT_OUTPUT_BITS,
  parameter int unsigned LEVEL_BITS    = DEFAULT_LEVEL_BITS,
  parameter int unsigned PRESCALE_BITS = 8,
  parameter int unsigned AMP_DEFAULT   = 4094
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          ENABLE,
  input  logic [PRESCALE_BITS-1:0]      DIV,
  input  logic [LEVEL_BITS-2:0]         AMP,
  input  logic [1:0]                    MODE,
  output logic signed [OUTPUT_BITS-1:0] CARRIER,
  output logic                          PEAK,
  output logic                          VALLEY,
  output logic                          LOCK
);

  localparam int unsigned Shift = OUTPUT_BITS - LEVEL_BITS;
  localparam logic [LEVEL_BITS-2:0] AmpRst = (LEVEL_BITS-1)'(AMP_DEFAULT);

  typedef logic signed [LEVEL_BITS-1:0] level_t;

  logic                          tick;
  level_t                        cnt_q, cnt_d, step_cnt, amp_s, neg_amp;
  dir_e                          dir_q, dir_d, step_dir;
  logic [LEVEL_BITS-2:0]         amp_r_q, amp_r_d;
  logic [1:0]                    mode_r_q, mode_r_d;
  logic                          up_eff, hit_peak, hit_valley, latch;
  logic                          peak_q, peak_d, valley_q, valley_d, lock_q, lock_d;
  logic signed [OUTPUT_BITS-1:0] carrier_q, carrier_d;

  ac_motor_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .en_i  (ENABLE),
    .div_i (DIV),
    .tick_o(tick)
  );

  always_comb begin
    amp_s    = level_t'({1'b0, amp_r_q});
    neg_amp  = -amp_s;
    up_eff   = 1'b0;
    step_cnt = cnt_q;
    step_dir = dir_q;
    case (mode_r_q)
      MODE_SAW_UP: step_cnt = (cnt_q >= amp_s) ? neg_amp : cnt_q + level_t'(1);
      MODE_SAW_DN: step_cnt = (cnt_q <= neg_amp) ? amp_s : cnt_q - level_t'(1);
      default: begin
        // Bounds compare (not equality) so a count left outside a newly latched range turns back.
        up_eff   = (dir_q == DirUp) ? (cnt_q < amp_s) : (cnt_q <= neg_amp);
        step_cnt = up_eff ? cnt_q + level_t'(1) : cnt_q - level_t'(1);
        if (step_cnt >= amp_s) begin
          step_dir = DirDown;
        end else if (step_cnt <= neg_amp) begin
          step_dir = DirUp;
        end else begin
          step_dir = up_eff ? DirUp : DirDown;
        end
      end
    endcase

    hit_peak   = (step_cnt == amp_s);
    hit_valley = (step_cnt == neg_amp);
    latch      = tick && ((mode_r_q == MODE_SAW_DN) ? hit_peak : hit_valley);

    cnt_d    = tick ? step_cnt : cnt_q;
    dir_d    = tick ? step_dir : dir_q;
    amp_r_d  = amp_r_q;
    mode_r_d = mode_r_q;
    if (latch) begin
      amp_r_d  = (AMP == '0) ? (LEVEL_BITS-1)'(1) : AMP;
      mode_r_d = MODE;
      dir_d    = DirUp;
    end

    peak_d    = tick && hit_peak;
    valley_d  = tick && hit_valley;
    lock_d    = ENABLE && (lock_q || valley_d);
    carrier_d = OUTPUT_BITS'(cnt_d) <<< Shift;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      dir_q     <= DirUp;
      amp_r_q   <= AmpRst;
      mode_r_q  <= MODE_TRI;
      peak_q    <= 1'b0;
      valley_q  <= 1'b0;
      lock_q    <= 1'b0;
      carrier_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      amp_r_q   <= amp_r_d;
      mode_r_q  <= mode_r_d;
      peak_q    <= peak_d;
      valley_q  <= valley_d;
      lock_q    <= lock_d;
      carrier_q <= carrier_d;
    end
  end

  assign CARRIER = carrier_q;
  assign PEAK    = peak_q;
  assign VALLEY  = valley_q;
  assign LOCK    = lock_q;

endmodule

// File: tb/tb_ac_motor_carrier.sv
// Directed bench for ac_motor_carrier; carrier values are cnt * 2048.
module tb_ac_motor_carrier;

  logic        CLK = 1'b0;
  logic        RESET_N, ENABLE;
  logic [7:0]  DIV;
  logic [11:0] AMP;
  logic [1:0]  MODE;
  logic [23:0] CARRIER;
  logic        PEAK, VALLEY, LOCK;

  int n_checks = 0;
  int n_fail   = 0;

  ac_motor_carrier #(
    .OUTPUT_BITS  (24),
    .LEVEL_BITS   (13),
    .PRESCALE_BITS(8),
    .AMP_DEFAULT  (3)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .ENABLE (ENABLE),
    .DIV    (DIV),
    .AMP    (AMP),
    .MODE   (MODE),
    .CARRIER(CARRIER),
    .PEAK   (PEAK),
    .VALLEY (VALLEY),
    .LOCK   (LOCK)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ENABLE = 1'b1; DIV = 8'd0; AMP = 12'd3; MODE = 2'd0;
    repeat (3) step();
    n_checks++;
    if (CARRIER !== 24'd0 || PEAK !== 1'b0 || VALLEY !== 1'b0 || LOCK !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got car=%0d pk=%b vl=%b lk=%b want 0 0 0 0",
               $signed(CARRIER), PEAK, VALLEY, LOCK);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_triangle();
    int seq [21] = '{1, 2, 3, 2, 1, 0, -1, -2, -3, -2, -1, 0, 1, 2, 3, 2, 1, 0, -1, -2, -3};
    for (int i = 0; i < 21; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== seq[i] * 2048) begin
        n_fail++;
        $display("FAIL tri_carrier[%0d]: got %0d want %0d", i, $signed(CARRIER), seq[i] * 2048);
      end
      n_checks++;
      if (PEAK !== (seq[i] == 3) || VALLEY !== (seq[i] == -3)) begin
        n_fail++;
        $display("FAIL tri_strobes[%0d]: got pk=%b vl=%b want pk=%b vl=%b", i, PEAK, VALLEY,
                 seq[i] == 3, seq[i] == -3);
      end
      n_checks++;
      if (LOCK !== (i >= 8)) begin
        n_fail++;
        $display("FAIL tri_lock[%0d]: got %b want %b", i, LOCK, i >= 8);
      end
    end
  endtask

  task automatic test_prescaler();
    int k;
    AMP = 12'd2; DIV = 8'd4;
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 100);
    n_checks++;
    if (!VALLEY) begin n_fail++; $display("FAIL presc_latch_valley: timeout after %0d", k); end
    k = 0;
    do begin step(); k++; end while (!PEAK && k < 100);
    n_checks++;
    if ($signed(CARRIER) !== 4096 || PEAK !== 1'b1) begin
      n_fail++;
      $display("FAIL presc_first_peak: got car=%0d pk=%b want 4096 1", $signed(CARRIER), PEAK);
    end
    step();
    n_checks++;
    if (PEAK !== 1'b0) begin n_fail++; $display("FAIL presc_peak_width: got %b want 0", PEAK); end
    k = 1;
    do begin step(); k++; end while (!PEAK && k < 100);
    n_checks++;
    if (k != 40) begin n_fail++; $display("FAIL presc_peak_spacing: got %0d want 40", k); end
    repeat (4) step();
    n_checks++;
    if ($signed(CARRIER) !== 4096) begin
      n_fail++;
      $display("FAIL presc_hold: got %0d want 4096", $signed(CARRIER));
    end
    step();
    n_checks++;
    if ($signed(CARRIER) !== 2048) begin
      n_fail++;
      $display("FAIL presc_step5: got %0d want 2048", $signed(CARRIER));
    end
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 100);
    step();
    n_checks++;
    if (VALLEY !== 1'b0 || $signed(CARRIER) !== -4096) begin
      n_fail++;
      $display("FAIL presc_valley_width: got vl=%b car=%0d want 0 -4096", VALLEY,
               $signed(CARRIER));
    end
  endtask

  task automatic test_saw_up();
    int k;
    int seq [10] = '{-1, 0, 1, 2, -2, -1, 0, 1, 2, -2};
    DIV = 8'd0; MODE = 2'd1;
    repeat (10) step();
    n_checks++;
    if ($signed(CARRIER) !== -4096) begin
      n_fail++;
      $display("FAIL saw_no_early_tick: got %0d want -4096", $signed(CARRIER));
    end
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 400);
    n_checks++;
    if (!VALLEY) begin n_fail++; $display("FAIL saw_latch_valley: timeout after %0d", k); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== seq[i] * 2048 || LOCK !== 1'b1) begin
        n_fail++;
        $display("FAIL saw_carrier[%0d]: got %0d lk=%b want %0d 1", i, $signed(CARRIER), LOCK,
                 seq[i] * 2048);
      end
      n_checks++;
      if (PEAK !== (seq[i] == 2) || VALLEY !== (seq[i] == -2)) begin
        n_fail++;
        $display("FAIL saw_strobes[%0d]: got pk=%b vl=%b want pk=%b vl=%b", i, PEAK, VALLEY,
                 seq[i] == 2, seq[i] == -2);
      end
    end
  endtask

  task automatic test_amp_change();
    int seq [21] = '{-1, 0, 1, 2, -2, -1, 0, 1, 2, 1, 0, -1, -2, -1, 0, 1, 2, 3, 4, 5, 4};
    bit pk [21]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit vl [21]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    MODE = 2'd0;
    for (int i = 0; i < 21; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== seq[i] * 2048) begin
        n_fail++;
        $display("FAIL amp_carrier[%0d]: got %0d want %0d", i, $signed(CARRIER), seq[i] * 2048);
      end
      n_checks++;
      if (PEAK !== pk[i] || VALLEY !== vl[i]) begin
        n_fail++;
        $display("FAIL amp_strobes[%0d]: got pk=%b vl=%b want pk=%b vl=%b", i, PEAK, VALLEY,
                 pk[i], vl[i]);
      end
      if (i == 7) AMP = 12'd5;
    end
  endtask

  task automatic test_enable();
    int seq [8] = '{2, 1, 0, -1, -2, -3, -4, -5};
    step();
    n_checks++;
    if ($signed(CARRIER) !== 6144 || LOCK !== 1'b1) begin
      n_fail++;
      $display("FAIL en_before: got car=%0d lk=%b want 6144 1", $signed(CARRIER), LOCK);
    end
    ENABLE = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== 6144 || PEAK !== 1'b0 || VALLEY !== 1'b0 || LOCK !== 1'b0) begin
        n_fail++;
        $display("FAIL en_frozen[%0d]: got car=%0d pk=%b vl=%b lk=%b want 6144 0 0 0", i,
                 $signed(CARRIER), PEAK, VALLEY, LOCK);
      end
    end
    ENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== seq[i] * 2048 || LOCK !== (i == 7) || VALLEY !== (i == 7)) begin
        n_fail++;
        $display("FAIL en_resume[%0d]: got car=%0d lk=%b vl=%b want %0d %b %b", i,
                 $signed(CARRIER), LOCK, VALLEY, seq[i] * 2048, i == 7, i == 7);
      end
    end
  endtask

  task automatic test_amp_zero();
    int k;
    AMP = 12'd0;
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 40);
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 40);
    n_checks++;
    if ($signed(CARRIER) !== -2048 || VALLEY !== 1'b1) begin
      n_fail++;
      $display("FAIL amp0_valley: got car=%0d vl=%b want -2048 1", $signed(CARRIER), VALLEY);
    end
    step();
    step();
    n_checks++;
    if ($signed(CARRIER) !== 2048 || PEAK !== 1'b1) begin
      n_fail++;
      $display("FAIL amp0_peak: got car=%0d pk=%b want 2048 1", $signed(CARRIER), PEAK);
    end
    step();
    step();
    n_checks++;
    if ($signed(CARRIER) !== -2048 || VALLEY !== 1'b1) begin
      n_fail++;
      $display("FAIL amp0_period: got car=%0d vl=%b want -2048 1", $signed(CARRIER), VALLEY);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int seq [4] = '{1, 2, 3, 2};
    MODE = 2'd2; AMP = 12'd1;
    k = 0;
    do begin step(); k++; end while (!VALLEY && k < 10);
    step();
    n_checks++;
    if ($signed(CARRIER) !== 2048 || PEAK !== 1'b1 || VALLEY !== 1'b0) begin
      n_fail++;
      $display("FAIL sawdn_wrap: got car=%0d pk=%b vl=%b want 2048 1 0", $signed(CARRIER), PEAK,
               VALLEY);
    end
    step();
    step();
    n_checks++;
    if ($signed(CARRIER) !== -2048 || VALLEY !== 1'b1 || LOCK !== 1'b1) begin
      n_fail++;
      $display("FAIL sawdn_valley: got car=%0d vl=%b lk=%b want -2048 1 1", $signed(CARRIER),
               VALLEY, LOCK);
    end
    RESET_N = 1'b0;
    step();
    n_checks++;
    if (CARRIER !== 24'd0 || LOCK !== 1'b0 || VALLEY !== 1'b0 || PEAK !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got car=%0d lk=%b vl=%b pk=%b want 0 0 0 0", $signed(CARRIER),
               LOCK, VALLEY, PEAK);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ($signed(CARRIER) !== seq[i] * 2048 || PEAK !== (seq[i] == 3 && i == 2)) begin
        n_fail++;
        $display("FAIL reset_defaults[%0d]: got car=%0d pk=%b want %0d %b", i, $signed(CARRIER),
                 PEAK, seq[i] * 2048, i == 2);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_triangle();
    test_prescaler();
    test_saw_up();
    test_amp_change();
    test_enable();
    test_amp_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_motor_carrier.md
Name: ac_motor_carrier

Overview:
- Parametrised PWM carrier generator for the AC motor drive. It is the successor to the fixed triangle source.
- Produces a signed, full-scale carrier whose amplitude, step rate and waveform mode (triangle, sawtooth up, sawtooth down) are selectable at runtime.
- Emits single-cycle peak/valley sync strobes and a LOCK level.
- Feeds the PWM comparators and the ADC-sampling trigger logic.

Parameters:
- OUTPUT_BITS, 24, width of the CARRIER output (signed).
- LEVEL_BITS, 13, width of the internal signed counter. LEVEL_BITS <= OUTPUT_BITS.
- PRESCALE_BITS, 8, width of the DIV input.
- AMP_DEFAULT, 4094, amplitude used after reset. Must be 1..2^(LEVEL_BITS-1)-1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- ENABLE  in  1  1 = run; 0 = freeze the carrier.
- DIV  in  PRESCALE_BITS  step every DIV+1 clocks.
- AMP  in  LEVEL_BITS-1  peak amplitude (unsigned); 0 is treated as 1.
- MODE  in  2  0 = triangle, 1 = saw up, 2 = saw down, 3 = triangle.
- CARRIER  out  OUTPUT_BITS  signed carrier, cnt * 2^(OUTPUT_BITS-LEVEL_BITS).
- PEAK  out  1  1-clock strobe when cnt reaches +amp_r.
- VALLEY  out  1  1-clock strobe when cnt reaches -amp_r.
- LOCK  out  1  high once a full period has started with latched settings.

Behaviour:
- Reset (RESET_N=0 at a clock edge):
  - cnt=0, dir=up, presc=0.
  - amp_r=AMP_DEFAULT, mode_r=triangle.
  - CARRIER=0, PEAK=0, VALLEY=0, LOCK=0.
- Prescaler:
  - presc counts 0..DIV. tick=1 on the cycle presc==DIV; presc then returns to 0.
  - DIV=0 gives a tick every clock.
  - A DIV change takes effect immediately. If presc>DIV, the next tick occurs when presc wraps to 0 and counts up to DIV; there is no early tick.
- Step on tick (ENABLE=1), per mode_r:
  - Triangle:
    - cnt moves ±1. At cnt==+amp_r dir becomes down; at cnt==-amp_r dir becomes up. No dwell at the extremes.
    - Period = 4*amp_r ticks.
  - Saw up: cnt+1 until +amp_r; the next tick loads -amp_r. Period = 2*amp_r+1 ticks.
  - Saw down: cnt-1 until -amp_r; the next tick loads +amp_r. Period = 2*amp_r+1 ticks.
- Parameter latching:
  - amp_r ← max(AMP,1) and mode_r ← MODE are loaded only on the tick on which cnt becomes -amp_r (valley event). For saw down, the latch happens on the wrap from -amp_r to +amp_r.
  - AMP/MODE changes mid-period are ignored until that point.
  - On a mode change into triangle, dir=up.
- Strobes:
  - PEAK/VALLEY are registered. They are high for exactly the clock after the tick that makes cnt equal ±amp_r.
  - In sawtooth modes, the wrap tick produces the opposite strobe: the saw-up wrap produces VALLEY, the saw-down wrap produces PEAK.
- CARRIER: registered from cnt, 1-clock latency, arithmetic left shift by OUTPUT_BITS-LEVEL_BITS with sign preserved.
- LOCK:
  - Set on the first VALLEY after reset or after ENABLE rises; stays high while ENABLE=1.
  - Cleared when ENABLE=0 or on reset.
- ENABLE=0:
  - cnt, dir, amp_r and mode_r hold; presc cleared.
  - PEAK/VALLEY forced 0; CARRIER keeps its value.
- Simultaneous events: reset dominates ENABLE, tick and latching. A valley tick latches the new parameters and steps in the same cycle; the step uses the old mode_r, the following steps use the new values.
- Overflow: with max amp_r, cnt stays within ±(2^(LEVEL_BITS-1)-1); no wrap is possible.

Decomposition:
- Shared package ac_motor_pkg holds:
  - Mode encoding constants MODE_TRI=2'd0, MODE_SAW_UP=2'd1, MODE_SAW_DN=2'd2.
  - The default LEVEL_BITS/OUTPUT_BITS values.
- One sub-module, ac_motor_prescaler: DIV-based tick generator with synchronous clear on !ENABLE or !RESET_N.
- The counter FSM and output registers stay in ac_motor_carrier.

Test Plan:
- Reset release, ENABLE=1, DIV=0, AMP=3, MODE=0 → cnt 0,1,2,3,2,…,-3 with VALLEY 1 clk after -3. After the first valley, with AMP=3 latched, the period is 12 clocks. LOCK rises with that VALLEY. CARRIER = -3*2048 = -6144 at the valley.
- DIV=4, triangle, AMP=2 → cnt changes every 5 clocks; PEAK pulses are 40 clocks apart; PEAK/VALLEY each exactly 1 clock wide.
- MODE=1, AMP=2 → sequence -2,-1,0,1,2,-2. Period 5 ticks. PEAK at 2, VALLEY at the wrap.
- AMP changed 2→5 at cnt=+1 in triangle → continues to ±2 until the next valley, then swings ±5. AMP=0 → behaves as amp 1, period 4.
- ENABLE dropped for 7 clocks mid-ramp → CARRIER frozen, strobes 0, LOCK falls. Resumes from the same cnt; LOCK re-asserts at the next VALLEY.
- RESET_N asserted mid-period with MODE=2 latched → next clock CARRIER=0, LOCK=0, mode triangle, amp AMP_DEFAULT.
